systema_reg_output: RTL
=======================

Name: systema_reg_output

Overview:
Avalon-MM slave output PIO driving an 8-bit `out_port` from a CPU-writable data register.
- Adds atomic bit set/clear writes.
- Adds a hardware-timed pulse engine: selected bits are inverted for a programmable number of clocks, then revert.
- Sits on the systema interconnect as the write-direction companion of the input PIO; shares its registered-readdata, zero-extended 32-bit read style.

Parameters:
- DATA_WIDTH, 8, width of `out_port` and of the data/mask registers.
- RESET_VALUE, 8'h00, value loaded into the data register on reset.
- LEN_WIDTH, 16, width of the pulse-length register and down-counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  register word select.
- chipselect  input  1  slave select; qualifies writes.
- write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data; upper unused bits ignored.
- readdata  output  32  registered read data, one-cycle latency.
- out_port  output  DATA_WIDTH  pin output, registered.

Behaviour:
- Register map:
  - 0 DATA: R/W data_reg.
  - 1 PLEN: R/W pulse_len[LEN_WIDTH-1:0].
  - 2 PULSE: W mask, R returns active pulse_mask.
  - 3 STATUS: R bit0=busy, bit1=overrun; any write clears overrun.
  - 4 OUTSET: W, data_reg |= wd.
  - 5 OUTCLR: W, data_reg &= ~wd.
  - 6-7: reads return 0, writes ignored.
- Reset (async, reset_n=0):
  - data_reg=RESET_VALUE, pulse_len=0, pulse_mask=0, cnt=0, overrun=0, readdata=0.
  - out_port=RESET_VALUE.
- readdata: updated every clock regardless of chipselect. Value is `{zero-extend, mux(address)}` sampled at the edge, so data appears the cycle after address is presented. It reflects register state before any same-cycle write.
- out_port: registered, equal to next-state `data_reg ^ pulse_mask`. A write to DATA/OUTSET/OUTCLR is visible on `out_port` exactly one clock after the write cycle.
- Pulse engine states:
  - IDLE (cnt=0, pulse_mask=0).
  - ACTIVE (cnt>0).
- IDLE -> ACTIVE: write to PULSE with wd[DATA_WIDTH-1:0]!=0 and pulse_len!=0. Load pulse_mask=wd, cnt=pulse_len.
  - Write to PULSE with mask 0 or pulse_len=0: no effect, no overrun.
- ACTIVE: cnt decrements each clock.
  - When cnt==1, next state is IDLE: pulse_mask=0, cnt=0.
  - The masked bits are therefore inverted on `out_port` for exactly pulse_len clocks.
- Write to PULSE while ACTIVE: ignored, overrun<=1. Pulse continues unchanged.
- DATA/OUTSET/OUTCLR writes during ACTIVE update data_reg normally. `out_port` shows the new data XOR the active mask.
- Pulse expiry in the same cycle as a data write: both apply. Next `out_port` = new data_reg, mask 0.
- Write to PLEN during ACTIVE updates pulse_len only; it does not affect the running count.
- busy = (cnt!=0).
- Overrun set and STATUS write in the same cycle: set wins.
- reset_n asserted mid-pulse: immediate return to reset values; no residual pulse after release.
- Widths: pulse_len max 2^LEN_WIDTH-1 clocks; counter never wraps (it stops at 0).

Decomposition:
- Package `systema_pio_pkg`:
  - Address constants ADDR_DATA..ADDR_OUTCLR.
  - STATUS bit indices.
  - Pulse-state enum {IDLE, ACTIVE}.
- One sub-module is natural: `systema_pio_pulse_timer`.
  - Holds the down-counter, mask register and overrun flag.
  - Inputs: load, mask, len, clr_ovr.
  - Outputs: pulse_mask, busy, overrun.
- The top holds data_reg, the write decode and the read mux.

Test Plan:
- Reset: hold reset_n=0 with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0; read addr 3 after release -> 0.
- Write DATA=8'h3C, then OUTSET 8'h01, then OUTCLR 8'h0C.
  - Required: out_port = 3C, 3D, 31 on successive cycles, each 1 clk after its write.
  - Read addr 0 -> 32'h00000031 one cycle after address.
- PLEN=5, DATA=8'h00, PULSE=8'h81.
  - Required: out_port=8'h81 for exactly 5 clocks, then 8'h00.
  - STATUS busy=1 during the pulse, 0 after.
- During a 10-clk pulse, write PULSE=8'h02.
  - Required: ignored, overrun=1; original pulse completes.
  - STATUS write clears overrun.
- PLEN=0 then PULSE=8'hFF -> no pulse, busy=0, overrun=0. PULSE=0 with PLEN=4 -> no pulse.
- Edge timing and reset:
  - OUTSET 8'h10 issued on the cycle the pulse expires -> out_port = new data, no mask.
  - Assert reset_n mid-pulse -> out_port=RESET_VALUE immediately, busy=0 after release.

Source files
------------

// File: rtl/systema_pio_pkg.sv
// Shared definitions for the systema output PIO: register map, STATUS bit
// positions and the pulse-engine state encoding.
package systema_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PLEN   = 3'd1;
  localparam logic [2:0] ADDR_PULSE  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVR  = 1;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/systema_pio_pulse_timer.sv
// Pulse engine: inverts the loaded mask for exactly len clocks, then clears
// itself. A load attempt while a pulse runs is dropped and flags overrun.
module systema_pio_pulse_timer
  import systema_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  clr_ovr_i,
  output logic [DATA_WIDTH-1:0] pulse_mask_o,
  output logic [DATA_WIDTH-1:0] mask_d_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  pulse_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  ovr_q, ovr_d;

  // State register: counter, active mask and overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next state: start on a non-trivial load, count down, drop mask at cnt==1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    ovr_d   = ovr_q;
    case (state_q)
      PULSE_IDLE: begin
        if (load_i && (mask_i != '0) && (len_i != '0)) begin
          state_d = PULSE_ACTIVE;
          cnt_d   = len_i;
          mask_d  = mask_i;
        end
      end
      PULSE_ACTIVE: begin
        if (cnt_q == LEN_WIDTH'(1)) begin
          state_d = PULSE_IDLE;
          cnt_d   = '0;
          mask_d  = '0;
        end else begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
        end
      end
      default: state_d = PULSE_IDLE;
    endcase
    // Set has priority over clear
    if (clr_ovr_i) ovr_d = 1'b0;
    if (load_i && (state_q == PULSE_ACTIVE)) ovr_d = 1'b1;
  end

  // Outputs: mask_d_o lets the parent register out_port from next-state mask
  always_comb begin
    busy_o       = (state_q == PULSE_ACTIVE);
    pulse_mask_o = mask_q;
    mask_d_o     = mask_d;
    overrun_o    = ovr_q;
  end

endmodule

// File: rtl/systema_reg_output.sv
// Avalon-MM output PIO: data register with atomic set/clear, a timed pulse
// engine XORed onto the pins, and a registered zero-extended read port.
module systema_reg_output
  import systema_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 8'h00,
  parameter int                    LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  plen_q, plen_d;
  logic [DATA_WIDTH-1:0] out_q;
  logic [31:0]           rd_q, rd_d;
  logic [DATA_WIDTH-1:0] pulse_mask, mask_d;
  logic                  busy, overrun;
  logic                  unused_wd;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  systema_pio_pulse_timer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (wr && (address == ADDR_PULSE)),
    .mask_i      (wd),
    .len_i       (plen_q),
    .clr_ovr_i   (wr && (address == ADDR_STATUS)),
    .pulse_mask_o(pulse_mask),
    .mask_d_o    (mask_d),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  // Write decode for data and pulse-length registers
  always_comb begin
    data_d = data_q;
    plen_d = plen_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = wd;
        ADDR_PLEN:   plen_d = writedata[LEN_WIDTH-1:0];
        ADDR_OUTSET: data_d = data_q | wd;
        ADDR_OUTCLR: data_d = data_q & ~wd;
        default:     ;
      endcase
    end
  end

  // Read mux over pre-write state; unmapped and write-only words read 0
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:   rd_d[DATA_WIDTH-1:0] = data_q;
      ADDR_PLEN:   rd_d[LEN_WIDTH-1:0]  = plen_q;
      ADDR_PULSE:  rd_d[DATA_WIDTH-1:0] = pulse_mask;
      ADDR_STATUS: begin
        rd_d[STAT_BUSY] = busy;
        rd_d[STAT_OVR]  = overrun;
      end
      default:     ;
    endcase
  end

  // Registers; out_port tracks next-state data XOR next-state mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      plen_q <= '0;
      out_q  <= RESET_VALUE;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      plen_q <= plen_d;
      out_q  <= data_d ^ mask_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;

endmodule
